vga_frame_reader: RTL and testbench
===================================

Name: vga_frame_reader

Overview:
- Display-side reader of the 160x120 capture frame buffer (15-bit address {x[7:0], y[6:0]}, 16-bit words {Cb/Cr, Y}).
- Generates 640x480@60 VGA timing from a divided pixel tick.
- Upscales each stored pixel 4x4 to fill the screen and drives grayscale RGB from the luma byte to the DAC.
- Sits on the RAM read port, opposite the camera write path.

Parameters:
- CLKDIV, 2, clk cycles per pixel tick (50 MHz clk gives a 25 MHz pixel rate); must be an even value >= 2.
- HACTIVE, 640, visible pixels per line.
- HFP, 16, horizontal front porch, in ticks.
- HSYNC, 96, hsync pulse width, in ticks.
- HBP, 48, horizontal back porch, in ticks.
- VACTIVE, 480, visible lines.
- VFP, 10, vertical front porch, in lines.
- VSYNC, 2, vsync pulse width, in lines.
- VBP, 33, vertical back porch, in lines.
- SHIFT, 2, log2 of the upscale factor.

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- rddata  input  16  RAM read data, valid 1 clk after rdaddr
- rdaddr  output  15  RAM read address {x[7:0], y[6:0]}
- vga_clk  output  1  pixel clock to DAC
- vga_hs  output  1  horizontal sync, active low
- vga_vs  output  1  vertical sync, active low
- vga_blank_n  output  1  high during the visible region
- vga_r  output  8  red
- vga_g  output  8  green
- vga_b  output  8  blue
- frame_start  output  1  1-clk pulse at the first visible tick of each frame

Behaviour:
- Divider: div counts 0..CLKDIV-1 and wraps.
  - pix_en = (div == CLKDIV-1).
  - vga_clk = (div >= CLKDIV/2), so outputs change on the vga_clk falling edge.
- Counters advance only on pix_en.
  - hcnt runs 0..HTOTAL-1, where HTOTAL = HACTIVE+HFP+HSYNC+HBP = 800.
  - vcnt increments when hcnt wraps and runs 0..VTOTAL-1, where VTOTAL = 525, then wraps to 0.
- Stage-0 decode (combinational from the counters):
  - active = hcnt < HACTIVE && vcnt < VACTIVE.
  - hs0 = 0 for hcnt in [HACTIVE+HFP, HACTIVE+HFP+HSYNC-1], i.e. 656..751.
  - vs0 = 0 for vcnt in [VACTIVE+VFP, VACTIVE+VFP+VSYNC-1], i.e. 490..491.
- rdaddr = active ? {hcnt[9:SHIFT] truncated to 8b, vcnt[8:SHIFT] truncated to 7b} : 0.
  - rdaddr is registered on each pix_en from the next counter values.
  - It is therefore stable for the whole tick, and rddata is valid CLKDIV-1 clks later.
- Output stage (registered on pix_en): samples rddata together with stage-0 active/hs/vs.
  - All outputs lag the counters by exactly 1 pixel tick.
  - Sync, blank and color stay mutually aligned.
- Color:
  - vga_r = vga_g = vga_b = active ? rddata[7:0] : 8'h00.
  - Y is the low byte of the stored word.
  - During blanking, color is forced to 0 regardless of rddata.
- Upscale:
  - Each rdaddr value repeats for 4 consecutive ticks.
  - Each address row repeats for 4 consecutive lines.
  - x spans 0..159 and y spans 0..119; no address outside 0..0x4FF7 is ever driven.
- frame_start: one clk pulse, coincident with the output update that presents hcnt=0, vcnt=0.
- Reset (any time, including mid-line or mid-sync):
  - div, hcnt and vcnt return to 0; rdaddr = 0.
  - vga_hs = vga_vs = 1; vga_blank_n = 0; rgb = 0; frame_start = 0; vga_clk = 0.
  - The first pixel tick after reset release restarts the frame at (0,0); no partial sync pulse is emitted.
- No handshake with the writer. Tearing is accepted, and reads never block.

Decomposition:
- Package vga_pkg holds:
  - timing defaults and derived HTOTAL/VTOTAL;
  - FB_W=160, FB_H=120;
  - address field widths (8, 7).
- Sub-module vga_timing (divider, hcnt/vcnt, active/hs0/vs0 decode).
- vga_frame_reader instantiates vga_timing and adds address generation, the output register stage and the luma mapping.

Test Plan:
- Reset mid-frame (assert at hcnt≈300, vcnt≈200 for 3 clks) -> outputs at reset values during reset; first frame_start exactly 1 tick after release; hcnt and vcnt restart at 0.
- Line and frame timing -> vga_hs low for 96 ticks, falling edge 657 ticks after line start (656+1 latency); period 800 ticks. vga_vs low for 2 lines starting at line 490; frame period 525 lines = 420000 ticks = 840000 clks.
- Addressing -> screen pixel (4,4) gives rdaddr 15'h0081; (639,479) gives {8'd159, 7'd119} = 15'h4FF7. Each address is held 4 ticks, each address row spans 4 lines, and rdaddr = 0 during blanking.
- Color path: RAM model returns rddata = 16'hAB5C at (0,0) -> next tick rgb = 5C/5C/5C with vga_blank_n = 1. At hcnt = 640 -> rgb = 00 and blank_n = 0 despite rddata = 16'hFFFF.
- Alignment: compare the hs/blank transitions against the counter decode -> exactly 1-tick lag on all outputs; vga_clk rising edge falls mid-tick relative to the output change.
- Full frame: RAM holds data = address -> each output luma equals the expected {x,y}[7:0] for all 307200 visible pixels.

Source files
------------

// File: rtl/vga_pkg.sv
// vga_pkg
//   Shared constants for the VGA frame-buffer reader: default 640x480@60
//   timing, derived line/frame totals, capture frame-buffer geometry and the
//   field widths of the {x, y} RAM address.
package vga_pkg;

    // Default 640x480@60 timing (counts of pixel ticks / lines)
    localparam int DEF_CLKDIV  = 2;
    localparam int DEF_HACTIVE = 640;
    localparam int DEF_HFP     = 16;
    localparam int DEF_HSYNC   = 96;
    localparam int DEF_HBP     = 48;
    localparam int DEF_VACTIVE = 480;
    localparam int DEF_VFP     = 10;
    localparam int DEF_VSYNC   = 2;
    localparam int DEF_VBP     = 33;
    localparam int DEF_SHIFT   = 2;

    localparam int HTOTAL = DEF_HACTIVE + DEF_HFP + DEF_HSYNC + DEF_HBP;
    localparam int VTOTAL = DEF_VACTIVE + DEF_VFP + DEF_VSYNC + DEF_VBP;

    // Capture frame buffer geometry
    localparam int FB_W = 160;
    localparam int FB_H = 120;

    // RAM address = {x[X_W-1:0], y[Y_W-1:0]}
    localparam int X_W    = 8;
    localparam int Y_W    = 7;
    localparam int ADDR_W = X_W + Y_W;

    // Counters are wide enough for up to 1023 ticks / lines
    localparam int CNT_W = 10;

endpackage

// File: rtl/vga_timing.sv
// vga_timing
//   Pixel-tick divider, horizontal/vertical counters and the stage-0
//   combinational decode of the visible region and sync pulses.
// Ports:
//   clk, reset      system clock, synchronous active-high reset
//   pix_en          1-clk strobe, last clk of each pixel tick
//   vga_clk         pixel clock, high during the second half of a tick
//   hcnt, vcnt      current counter values
//   hcnt_nxt,
//   vcnt_nxt        values the counters take at the next clk edge
//   active,hs0,vs0  decode of the current counters (sync active low)
//   active_nxt      visible-region decode of the next counter values
module vga_timing
    import vga_pkg::*;
#(
    parameter int CLKDIV  = DEF_CLKDIV,
    parameter int HACTIVE = DEF_HACTIVE,
    parameter int HFP     = DEF_HFP,
    parameter int HSYNC   = DEF_HSYNC,
    parameter int HBP     = DEF_HBP,
    parameter int VACTIVE = DEF_VACTIVE,
    parameter int VFP     = DEF_VFP,
    parameter int VSYNC   = DEF_VSYNC,
    parameter int VBP     = DEF_VBP
) (
    input  logic             clk,
    input  logic             reset,
    output logic             pix_en,
    output logic             vga_clk,
    output logic [CNT_W-1:0] hcnt,
    output logic [CNT_W-1:0] vcnt,
    output logic [CNT_W-1:0] hcnt_nxt,
    output logic [CNT_W-1:0] vcnt_nxt,
    output logic             active,
    output logic             hs0,
    output logic             vs0,
    output logic             active_nxt
);

    localparam int DIV_W = (CLKDIV > 2) ? $clog2(CLKDIV) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLKDIV - 1);
    localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(CLKDIV / 2);

    localparam logic [CNT_W-1:0] H_LAST     = CNT_W'(HACTIVE + HFP + HSYNC + HBP - 1);
    localparam logic [CNT_W-1:0] V_LAST     = CNT_W'(VACTIVE + VFP + VSYNC + VBP - 1);
    localparam logic [CNT_W-1:0] H_VIS      = CNT_W'(HACTIVE);
    localparam logic [CNT_W-1:0] V_VIS      = CNT_W'(VACTIVE);
    localparam logic [CNT_W-1:0] HS_START   = CNT_W'(HACTIVE + HFP);
    localparam logic [CNT_W-1:0] HS_END     = CNT_W'(HACTIVE + HFP + HSYNC - 1);
    localparam logic [CNT_W-1:0] VS_START   = CNT_W'(VACTIVE + VFP);
    localparam logic [CNT_W-1:0] VS_END     = CNT_W'(VACTIVE + VFP + VSYNC - 1);

    function automatic logic is_visible(input logic [CNT_W-1:0] h,
                                        input logic [CNT_W-1:0] v);
        return (h < H_VIS) && (v < V_VIS);
    endfunction

    logic [DIV_W-1:0] div;
    logic [DIV_W-1:0] div_nxt;

    assign pix_en = (div == DIV_LAST);

    always_comb begin
        div_nxt  = div + 1'b1;
        hcnt_nxt = hcnt;
        vcnt_nxt = vcnt;
        if (pix_en) begin
            div_nxt = '0;
            if (hcnt == H_LAST) begin
                hcnt_nxt = '0;
                vcnt_nxt = (vcnt == V_LAST) ? '0 : vcnt + 1'b1;
            end else begin
                hcnt_nxt = hcnt + 1'b1;
            end
        end
    end

    // vga_clk is registered from the next divider value so it equals
    // (div >= CLKDIV/2) without a combinational glitch path to the pin.
    always_ff @(posedge clk) begin
        if (reset) begin
            div     <= '0;
            hcnt    <= '0;
            vcnt    <= '0;
            vga_clk <= 1'b0;
        end else begin
            div     <= div_nxt;
            hcnt    <= hcnt_nxt;
            vcnt    <= vcnt_nxt;
            vga_clk <= (div_nxt >= DIV_HALF);
        end
    end

    assign active     = is_visible(hcnt, vcnt);
    assign active_nxt = is_visible(hcnt_nxt, vcnt_nxt);
    assign hs0        = !((hcnt >= HS_START) && (hcnt <= HS_END));
    assign vs0        = !((vcnt >= VS_START) && (vcnt <= VS_END));

endmodule

// File: rtl/vga_frame_reader.sv
// vga_frame_reader
//   Reads the 160x120 capture frame buffer and displays it 4x4-upscaled as
//   grayscale 640x480@60 VGA. Luma is the low byte of each stored word.
// Ports:
//   clk, reset   system clock, synchronous active-high reset
//   rddata       RAM read data, valid 1 clk after rdaddr
//   rdaddr       RAM read address {x[7:0], y[6:0]}, 0 during blanking
//   vga_clk      pixel clock to the DAC
//   vga_hs/vs    syncs, active low
//   vga_blank_n  high in the visible region
//   vga_r/g/b    grayscale color
//   frame_start  1-clk pulse with the output update presenting (0,0)
module vga_frame_reader
    import vga_pkg::*;
#(
    parameter int CLKDIV  = DEF_CLKDIV,
    parameter int HACTIVE = DEF_HACTIVE,
    parameter int HFP     = DEF_HFP,
    parameter int HSYNC   = DEF_HSYNC,
    parameter int HBP     = DEF_HBP,
    parameter int VACTIVE = DEF_VACTIVE,
    parameter int VFP     = DEF_VFP,
    parameter int VSYNC   = DEF_VSYNC,
    parameter int VBP     = DEF_VBP,
    parameter int SHIFT   = DEF_SHIFT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [15:0]       rddata,
    output logic [ADDR_W-1:0] rdaddr,
    output logic              vga_clk,
    output logic              vga_hs,
    output logic              vga_vs,
    output logic              vga_blank_n,
    output logic [7:0]        vga_r,
    output logic [7:0]        vga_g,
    output logic [7:0]        vga_b,
    output logic              frame_start
);

    function automatic logic [7:0] luma_of(input logic [7:0] y, input logic vis);
        return vis ? y : 8'h00;
    endfunction

    logic             vld_p0;
    logic [CNT_W-1:0] hcnt;
    logic [CNT_W-1:0] vcnt;
    logic [CNT_W-1:0] hcnt_nxt;
    logic [CNT_W-1:0] vcnt_nxt;
    logic             active_p0;
    logic             active_nxt;
    logic             hs_p0;
    logic             vs_p0;
    logic             first_p0;
    logic [X_W-1:0]   ax_nxt;
    logic [Y_W-1:0]   ay_nxt;
    logic [7:0]       luma_p1;
    logic             unused_chroma;

    vga_timing #(
        .CLKDIV  (CLKDIV),
        .HACTIVE (HACTIVE),
        .HFP     (HFP),
        .HSYNC   (HSYNC),
        .HBP     (HBP),
        .VACTIVE (VACTIVE),
        .VFP     (VFP),
        .VSYNC   (VSYNC),
        .VBP     (VBP)
    ) u_timing (
        .clk        (clk),
        .reset      (reset),
        .pix_en     (vld_p0),
        .vga_clk    (vga_clk),
        .hcnt       (hcnt),
        .vcnt       (vcnt),
        .hcnt_nxt   (hcnt_nxt),
        .vcnt_nxt   (vcnt_nxt),
        .active     (active_p0),
        .hs0        (hs_p0),
        .vs0        (vs_p0),
        .active_nxt (active_nxt)
    );

    // Dropping the low SHIFT bits of the screen counters gives the 4x4
    // pixel replication; the casts keep only the address field widths.
    assign ax_nxt        = X_W'(hcnt_nxt >> SHIFT);
    assign ay_nxt        = Y_W'(vcnt_nxt >> SHIFT);
    assign first_p0      = (hcnt == '0) && (vcnt == '0);
    assign unused_chroma = ^rddata[15:8];

    // Stage 0 -> 1: the address for the coming tick is launched at the same
    // edge the counters advance, so rddata settles well before the next
    // pix_en samples it alongside that tick's sync/blank decode.
    always_ff @(posedge clk) begin
        if (reset) begin
            rdaddr      <= '0;
            vga_hs      <= 1'b1;
            vga_vs      <= 1'b1;
            vga_blank_n <= 1'b0;
            luma_p1     <= 8'h00;
            frame_start <= 1'b0;
        end else begin
            frame_start <= vld_p0 && first_p0;
            if (vld_p0) begin
                rdaddr      <= active_nxt ? {ax_nxt, ay_nxt} : '0;
                vga_hs      <= hs_p0;
                vga_vs      <= vs_p0;
                vga_blank_n <= active_p0;
                luma_p1     <= luma_of(rddata[7:0], active_p0);
            end
        end
    end

    assign vga_r = luma_p1;
    assign vga_g = luma_p1;
    assign vga_b = luma_p1;

endmodule

// File: tb/tb_vga_frame_reader.sv
module tb_vga_frame_reader;

    localparam int CLKDIV = 4;
    localparam int HA  = 32;
    localparam int HFP = 4;
    localparam int HSY = 8;
    localparam int HBP = 4;
    localparam int VA  = 24;
    localparam int VFP = 2;
    localparam int VSY = 2;
    localparam int VBP = 3;
    localparam int SH  = 2;
    localparam int HT  = HA + HFP + HSY + HBP;
    localparam int VT  = VA + VFP + VSY + VBP;
    localparam int FRAME = HT * VT;

    typedef struct {
        logic        hs;
        logic        vs;
        logic        bn;
        logic        fs;
        logic [7:0]  y;
        logic [14:0] addr;
    } exp_t;

    logic        clk;
    logic        rst;
    logic [15:0] rddata;
    logic [14:0] rdaddr;
    logic        vga_clk, vga_hs, vga_vs, vga_blank_n, frame_start;
    logic [7:0]  vga_r, vga_g, vga_b;

    logic [15:0] mem [0:32767];
    exp_t        q[$];
    int          checks = 0;
    int          errors = 0;

    vga_frame_reader #(
        .CLKDIV(CLKDIV), .HACTIVE(HA), .HFP(HFP), .HSYNC(HSY), .HBP(HBP),
        .VACTIVE(VA), .VFP(VFP), .VSYNC(VSY), .VBP(VBP), .SHIFT(SH)
    ) dut (
        .clk(clk), .reset(rst), .rddata(rddata), .rdaddr(rdaddr),
        .vga_clk(vga_clk), .vga_hs(vga_hs), .vga_vs(vga_vs),
        .vga_blank_n(vga_blank_n), .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
        .frame_start(frame_start)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous RAM: one clk read latency
    always @(posedge clk) rddata <= mem[rdaddr];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [14:0] addr_of(input int h, input int v);
        int a;
        if (h < HA && v < VA) a = ((h / (1 << SH)) * 128) + (v / (1 << SH));
        else a = 0;
        return 15'(a);
    endfunction

    // Update k (k >= 1 after reset release) shows screen position k-1; the
    // address on the bus during the following tick belongs to position k.
    function automatic exp_t model(input int k);
        exp_t e;
        int h, v, ha, va;
        logic [14:0] a;
        logic [15:0] w;
        h  = (k - 1) % HT;
        v  = ((k - 1) / HT) % VT;
        ha = k % HT;
        va = (k / HT) % VT;
        e.bn   = (h < HA) && (v < VA);
        e.hs   = !(h >= HA + HFP && h < HA + HFP + HSY);
        e.vs   = !(v >= VA + VFP && v < VA + VFP + VSY);
        e.fs   = (h == 0) && (v == 0);
        a      = addr_of(h, v);
        w      = mem[a];
        e.y    = e.bn ? w[7:0] : 8'h00;
        e.addr = addr_of(ha, va);
        return e;
    endfunction

    task automatic fill_mem();
        for (int i = 0; i < 32768; i++) mem[i] = 16'($urandom);
        mem[0] = 16'hAB5C;
    endtask

    task automatic check_reset_outputs();
        chk("rst_hs", 32'(vga_hs), 32'(1));
        chk("rst_vs", 32'(vga_vs), 32'(1));
        chk("rst_blank_n", 32'(vga_blank_n), 32'(0));
        chk("rst_r", 32'(vga_r), 32'(0));
        chk("rst_g", 32'(vga_g), 32'(0));
        chk("rst_b", 32'(vga_b), 32'(0));
        chk("rst_frame_start", 32'(frame_start), 32'(0));
        chk("rst_vga_clk", 32'(vga_clk), 32'(0));
        chk("rst_rdaddr", 32'(rdaddr), 32'(0));
    endtask

    // Monitor: own clk count since reset release decides when a tick ends
    initial begin
        int   cyc;
        logic r;
        exp_t e;
        cyc = 0;
        forever begin
            @(posedge clk);
            r = rst;
            #1;
            if (r) begin
                cyc = 0;
            end else begin
                cyc++;
                chk("vga_clk_phase", 32'(vga_clk), 32'((cyc % CLKDIV) >= (CLKDIV / 2)));
                if (cyc % CLKDIV == 0) begin
                    if (q.size() > 0) begin
                        e = q.pop_front();
                        chk("hs", 32'(vga_hs), 32'(e.hs));
                        chk("vs", 32'(vga_vs), 32'(e.vs));
                        chk("blank_n", 32'(vga_blank_n), 32'(e.bn));
                        chk("frame_start", 32'(frame_start), 32'(e.fs));
                        chk("r", 32'(vga_r), 32'(e.y));
                        chk("g", 32'(vga_g), 32'(e.y));
                        chk("b", 32'(vga_b), 32'(e.y));
                        chk("rdaddr", 32'(rdaddr), 32'(e.addr));
                    end
                end else begin
                    chk("frame_start_width", 32'(frame_start), 32'(0));
                end
            end
        end
    end

    // Stimulus
    initial begin
        int seg_len [3];
        rst = 1'b1;
        fill_mem();
        repeat (2) @(posedge clk);
        #1 check_reset_outputs();

        seg_len[0] = FRAME + $urandom_range(HT * 4, HT * 20);
        seg_len[1] = $urandom_range(HT * (VA + VFP), HT * (VA + VFP + VSY) + HA + HFP + 2);
        seg_len[2] = 2 * FRAME + $urandom_range(1, 100);

        for (int s = 0; s < 3; s++) begin
            int n;
            int budget;
            bit found;
            if (s > 0) begin
                @(negedge clk);
                rst = 1'b1;
                fill_mem();
                repeat (3) begin
                    @(posedge clk);
                    #1 check_reset_outputs();
                end
            end
            @(negedge clk);
            for (int k = 1; k <= seg_len[s]; k++) q.push_back(model(k));
            rst = 1'b0;

            n = 0;
            found = 1'b0;
            while (n < 4 * CLKDIV && !found) begin
                @(posedge clk);
                #1;
                n++;
                if (frame_start) found = 1'b1;
            end
            chk("first_frame_start_delay", 32'(n), 32'(CLKDIV));

            budget = (seg_len[s] + 20) * CLKDIV;
            while (q.size() > 0 && budget > 0) begin
                @(posedge clk);
                #2;
                budget--;
            end
            chk("drain_timeout", 32'(q.size()), 32'(0));
            q.delete();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
